prga: RTL and testbench

- Pseudo-random generation stage of the ARC4 decryptor. Runs after the KSA stage has scrambled S memory.
- Reads the length-prefixed ciphertext from CT memory.
- Generates one keystream byte per message byte, swapping S entries as it goes, and writes the length-prefixed plaintext to PT memory.
- Controlled by the arc4 top-level FSM through the rdy/en handshake.

---
 rtl/prga_if.sv | 26 ++
 rtl/prga.sv | 143 ++++++++++++++
 tb/tb_prga.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/prga_if.sv
// Handshake and memory-port bundle between the PRGA stage and its controller/memories.
// master = PRGA side (drives addresses/writes, reads data); slave = controller and memory side.
interface prga_if;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr;
  logic [7:0] s_rddata;
  logic [7:0] s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr;
  logic [7:0] ct_rddata;
  logic [7:0] pt_addr;
  logic [7:0] pt_rddata;
  logic [7:0] pt_wrdata;
  logic       pt_wren;

  modport master (
    input  en, s_rddata, ct_rddata, pt_rddata,
    output rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );

  modport slave (
    output en, s_rddata, ct_rddata, pt_rddata,
    input  rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );
endinterface

// File: rtl/prga.sv
// ARC4 keystream stage: decrypts length-prefixed CT into PT, swapping S as it goes; rdy back 3+6L cycles after en.
// en is only honoured while rdy=1; memories are synchronous with 1-cycle read latency, no stalls.
module prga (
  input  logic   clk,
  input  logic   rst,
  prga_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, LEN_A, LEN_D, B0, B1, B2, B3, B4, B5
  } state_t;

  state_t     state_q;
  logic       rdy_q;
  logic [7:0] i_q, j_q, k_q, len_q, si_q, sj_q;
  logic [7:0] i_d, j_d;

  logic [7:0] s_addr, s_wrdata, ct_addr, pt_addr, pt_wrdata;
  logic       s_wren, pt_wren;
  logic       unused_pt_rddata;

  assign i_d = i_q + 8'd1;
  assign j_d = j_q + bus.s_rddata;
  assign unused_pt_rddata = ^bus.pt_rddata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdy_q   <= 1'b1;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      k_q     <= 8'd0;
      len_q   <= 8'd0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.en) begin
            state_q <= LEN_A;
            rdy_q   <= 1'b0;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
          end
        end
        LEN_A: state_q <= LEN_D;
        LEN_D: begin
          len_q <= bus.ct_rddata;
          k_q   <= 8'd1;
          if (bus.ct_rddata == 8'd0) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
          end else begin
            state_q <= B0;
          end
        end
        B0: begin
          i_q     <= i_d;
          state_q <= B1;
        end
        B1: begin
          si_q    <= bus.s_rddata;
          j_q     <= j_d;
          state_q <= B2;
        end
        B2: begin
          sj_q    <= bus.s_rddata;
          state_q <= B3;
        end
        B3: state_q <= B4;
        B4: state_q <= B5;
        B5: begin
          // k stops at len, so len=255 never wraps k
          if (k_q == len_q) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
          end else begin
            k_q     <= k_q + 8'd1;
            state_q <= B0;
          end
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  // Memory ports are decoded from state because read data arrives mid-state.
  always_comb begin
    s_addr    = 8'd0;
    s_wrdata  = 8'd0;
    s_wren    = 1'b0;
    ct_addr   = 8'd0;
    pt_addr   = 8'd0;
    pt_wrdata = 8'd0;
    pt_wren   = 1'b0;
    case (state_q)
      LEN_D: begin
        pt_wrdata = bus.ct_rddata;
        pt_wren   = 1'b1;
      end
      B0: s_addr = i_d;
      B1: s_addr = j_d;
      B2: begin
        s_addr   = i_q;
        s_wrdata = bus.s_rddata;
        s_wren   = 1'b1;
      end
      B3: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
      end
      B4: begin
        s_addr  = si_q + sj_q;
        ct_addr = k_q;
      end
      B5: begin
        pt_addr   = k_q;
        pt_wrdata = bus.s_rddata ^ bus.ct_rddata;
        pt_wren   = 1'b1;
      end
      default: ;
    endcase
    // A reset cycle must not corrupt memory even when it lands on a write state.
    if (rst) begin
      s_wren  = 1'b0;
      pt_wren = 1'b0;
    end
  end

  assign bus.rdy       = rdy_q;
  assign bus.s_addr    = s_addr;
  assign bus.s_wrdata  = s_wrdata;
  assign bus.s_wren    = s_wren;
  assign bus.ct_addr   = ct_addr;
  assign bus.pt_addr   = pt_addr;
  assign bus.pt_wrdata = pt_wrdata;
  assign bus.pt_wren   = pt_wren;

endmodule

// File: tb/tb_prga.sv
// Bench for prga: synchronous memory models, ARC4 reference model, directed and randomized runs.
module tb_prga;
  logic clk = 1'b0;
  logic rst;
  logic load;
  always #5 clk = ~clk;

  prga_if bus();
  prga dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] s_init [256];
  logic [7:0] ct_img [256];
  logic [7:0] s_mem  [256];
  logic [7:0] pt_mem [256];
  logic       pt_wflag [256];
  int         s_wr_cnt = 0;
  int         pt_wr_cnt = 0;

  int         exp_pt [256];
  int         exp_s  [256];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         cyc;

  always @(posedge clk) begin
    if (load) begin
      for (int a = 0; a < 256; a++) begin
        s_mem[a]    <= s_init[a];
        pt_mem[a]   <= 8'h00;
        pt_wflag[a] <= 1'b0;
      end
      s_wr_cnt  <= 0;
      pt_wr_cnt <= 0;
    end else begin
      if (bus.s_wren) begin
        s_mem[bus.s_addr] <= bus.s_wrdata;
        s_wr_cnt <= s_wr_cnt + 1;
      end
      if (bus.pt_wren) begin
        pt_mem[bus.pt_addr]   <= bus.pt_wrdata;
        pt_wflag[bus.pt_addr] <= 1'b1;
        pt_wr_cnt <= pt_wr_cnt + 1;
      end
    end
    bus.s_rddata  <= s_mem[bus.s_addr];
    bus.ct_rddata <= ct_img[bus.ct_addr];
    bus.pt_rddata <= pt_mem[bus.pt_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_identity();
    for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
  endtask

  task automatic set_perm();
    logic [7:0] t;
    int r;
    set_identity();
    for (int a = 255; a > 0; a--) begin
      r = $urandom_range(a, 0);
      t = s_init[a];
      s_init[a] = s_init[r];
      s_init[r] = t;
    end
  endtask

  task automatic set_ct(input int len);
    for (int a = 0; a < 256; a++) ct_img[a] = 8'($urandom);
    ct_img[0] = 8'(len);
  endtask

  // Plain ARC4 PRGA over the whole message, independent of any cycle timing.
  task automatic model(input int len);
    int i, j, t;
    for (int a = 0; a < 256; a++) exp_s[a] = int'(s_init[a]);
    i = 0;
    j = 0;
    exp_pt[0] = len;
    for (int k = 1; k <= len; k++) begin
      i = (i + 1) % 256;
      j = (j + exp_s[i]) % 256;
      t = exp_s[i];
      exp_s[i] = exp_s[j];
      exp_s[j] = t;
      exp_pt[k] = int'(ct_img[k]) ^ exp_s[(exp_s[i] + exp_s[j]) % 256];
    end
  endtask

  task automatic do_run(input string tag, input bit toggle, output int ncyc);
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk({tag, "_start_rdy"}, 32'(bus.rdy), 32'd1);
    bus.en = 1'b1;
    ncyc = 0;
    while (ncyc < 2000) begin
      @(negedge clk);
      ncyc++;
      if (bus.rdy === 1'b1) break;
      bus.en = toggle ? 1'($urandom) : 1'b0;
    end
    bus.en = 1'b0;
  endtask

  task automatic verify(input string tag, input int len, input int ncyc);
    int bad_s, stray;
    chk({tag, "_cycles"}, 32'(ncyc), 32'(3 + 6 * len));
    chk({tag, "_pt_writes"}, 32'(pt_wr_cnt), 32'(len + 1));
    chk({tag, "_s_writes"}, 32'(s_wr_cnt), 32'(2 * len));
    for (int k = 0; k <= len; k++)
      chk($sformatf("%s_pt[%0d]", tag, k), 32'(pt_mem[k]), 32'(exp_pt[k]));
    bad_s = 0;
    for (int a = 0; a < 256; a++) if (int'(s_mem[a]) != exp_s[a]) bad_s++;
    chk({tag, "_s_bad_entries"}, 32'(bad_s), 32'd0);
    stray = 0;
    for (int a = len + 1; a < 256; a++) if (pt_wflag[a]) stray++;
    chk({tag, "_pt_above_len"}, 32'(stray), 32'd0);
  endtask

  initial begin
    int len;
    rst = 1'b1;
    load = 1'b0;
    bus.en = 1'b0;
    set_identity();
    set_ct(0);

    // Reset for two cycles with an en pulse inside it.
    @(negedge clk);
    bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", 32'(bus.rdy), 32'd1);
    chk("rst_s_wren", 32'(bus.s_wren), 32'd0);
    chk("rst_pt_wren", 32'(bus.pt_wren), 32'd0);
    chk("rst_s_addr", 32'(bus.s_addr), 32'd0);
    chk("rst_ct_addr", 32'(bus.ct_addr), 32'd0);
    chk("rst_pt_addr", 32'(bus.pt_addr), 32'd0);
    chk("rst_pt_wrdata", 32'(bus.pt_wrdata), 32'd0);
    repeat (4) @(negedge clk);
    chk("rst_still_rdy", 32'(bus.rdy), 32'd1);
    chk("rst_no_pt_write", 32'(pt_wr_cnt), 32'd0);
    chk("rst_no_s_write", 32'(s_wr_cnt), 32'd0);

    // Single byte, identity S.
    set_identity();
    set_ct(1);
    ct_img[1] = 8'h41;
    model(1);
    do_run("one", 1'b0, cyc);
    verify("one", 1, cyc);
    chk("one_pt1_lit", 32'(pt_mem[1]), 32'h43);
    chk("one_s1_lit", 32'(s_mem[1]), 32'h01);

    // Two bytes, identity S.
    set_identity();
    set_ct(2);
    ct_img[1] = 8'h41;
    ct_img[2] = 8'h00;
    model(2);
    do_run("two", 1'b0, cyc);
    verify("two", 2, cyc);
    chk("two_pt2_lit", 32'(pt_mem[2]), 32'h05);
    chk("two_s2_lit", 32'(s_mem[2]), 32'h03);
    chk("two_s3_lit", 32'(s_mem[3]), 32'h02);

    // Zero length.
    set_perm();
    set_ct(0);
    model(0);
    do_run("zero", 1'b0, cyc);
    verify("zero", 0, cyc);
    chk("zero_cycles_lit", 32'(cyc), 32'd3);

    // Maximum length with identity S.
    set_identity();
    set_ct(255);
    model(255);
    do_run("max", 1'b0, cyc);
    verify("max", 255, cyc);
    chk("max_cycles_lit", 32'(cyc), 32'd1533);

    // Reset landing in byte 3, state B2 (cycle 17 after accept).
    set_perm();
    set_ct(10);
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    bus.en = 1'b1;
    repeat (17) begin
      @(negedge clk);
      bus.en = 1'b0;
    end
    chk("mid_b2_wren", 32'(bus.s_wren), 32'd1);
    chk("mid_b2_addr", 32'(bus.s_addr), 32'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_s_wren", 32'(bus.s_wren), 32'd0);
    chk("mid_rst_pt_wren", 32'(bus.pt_wren), 32'd0);
    @(negedge clk);
    chk("mid_rst_rdy", 32'(bus.rdy), 32'd1);
    chk("mid_rst_s_writes", 32'(s_wr_cnt), 32'd4);
    chk("mid_rst_pt_writes", 32'(pt_wr_cnt), 32'd3);
    rst = 1'b0;
    model(10);
    do_run("after_rst", 1'b1, cyc);
    verify("after_rst", 10, cyc);

    // Randomized runs with en toggling while busy.
    for (int r = 0; r < 5; r++) begin
      len = $urandom_range(60, 1);
      set_perm();
      set_ct(len);
      model(len);
      do_run($sformatf("rnd%0d", r), 1'b1, cyc);
      verify($sformatf("rnd%0d", r), len, cyc);
    end

    repeat (3) @(negedge clk);
    chk("end_rdy", 32'(bus.rdy), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
